// File: rtl/vga_overlay_mixer.sv
// vga_overlay_mixer: bit-plane pixel to RGB mixer with crosshair/blink cursor, border and test bars.
// Latency: 2 VCLK cycles from pixel/sync inputs to oVGA_* outputs; oFRAME_TICK 1 cycle after iVSYNC rises.
// Backpressure: none; one pixel per VCLK, the downstream transmitter must accept every cycle.
module vga_overlay_mixer #(
  parameter int ADDR_WIDTH   = 11,
  parameter int HACTIVE      = 640,
  parameter int VACTIVE      = 480,
  parameter int PIXEL_WIDTH  = 8,
  parameter int NUM_PLANES   = 6,
  parameter logic [PIXEL_WIDTH-1:0]   MASK_LEVEL = 8'hC0,
  parameter logic [3*PIXEL_WIDTH-1:0] CURSOR_RGB = 24'hFF0000,
  parameter logic [3*PIXEL_WIDTH-1:0] BORDER_RGB = 24'h00FF00,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                   VCLK,
  input  logic                   RST,
  input  logic                   iVSYNC,
  input  logic                   iHSYNC,
  input  logic                   iDE,
  input  logic [ADDR_WIDTH-1:0]  iH_ADDR,
  input  logic [ADDR_WIDTH-1:0]  iV_ADDR,
  input  logic [NUM_PLANES-1:0]  iPLANE_BITS,
  input  logic [1:0]             iMODE,
  input  logic                   iCURSOR_EN,
  input  logic                   iBLINK_EN,
  input  logic [ADDR_WIDTH-1:0]  iPOINT_X,
  input  logic [ADDR_WIDTH-1:0]  iPOINT_Y,
  output logic                   oVGA_HSYNC,
  output logic                   oVGA_VSYNC,
  output logic                   oVGA_DE,
  output logic [PIXEL_WIDTH-1:0] oVGA_R,
  output logic [PIXEL_WIDTH-1:0] oVGA_G,
  output logic [PIXEL_WIDTH-1:0] oVGA_B,
  output logic                   oFRAME_TICK
);

  localparam int NG  = NUM_PLANES - 1;
  localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FCW-1:0]        BLINK_LAST = FCW'(BLINK_FRAMES - 1);
  localparam logic [ADDR_WIDTH-1:0] H_LAST     = ADDR_WIDTH'(HACTIVE - 1);
  localparam logic [ADDR_WIDTH-1:0] V_LAST     = ADDR_WIDTH'(VACTIVE - 1);
  localparam logic [ADDR_WIDTH-1:0] BAR_DIV    = ADDR_WIDTH'(HACTIVE / 8);
  localparam logic [ADDR_WIDTH-1:0] ONE        = ADDR_WIDTH'(1);

  // frame-rate state
  logic                  vs_q;
  logic                  vs_rise;
  logic [ADDR_WIDTH-1:0] shadow_x, shadow_y;
  logic [FCW-1:0]        frame_cnt;
  logic                  blink_phase;

  // stage-0 combinational compares
  logic [ADDR_WIDTH-1:0] dh, dv, bar_full;
  logic                  line_c, near_c, edge_c, cur_vis_c;
  logic [2:0]            bar_c;

  // stage-1 registers
  logic                  s1_de, s1_hs, s1_vs;
  logic [NUM_PLANES-1:0] s1_planes;
  logic [1:0]            s1_mode;
  logic                  s1_line, s1_near, s1_edge, s1_cur_en, s1_cur_vis;
  logic [2:0]            s1_bar;

  // stage-2 colour
  logic [NG-1:0]                grey_msb;
  logic [NG+PIXEL_WIDTH-1:0]    grey_pad;
  logic [PIXEL_WIDTH-1:0]       grey, mask_g;
  logic [3*PIXEL_WIDTH-1:0]     rgb_c;

  assign vs_rise = iVSYNC & ~vs_q;

  // Frame edge: tick, shadow the cursor position, advance blink counter/phase
  always_ff @(posedge VCLK or posedge RST) begin
    if (RST) begin
      vs_q        <= 1'b0;
      oFRAME_TICK <= 1'b0;
      shadow_x    <= '0;
      shadow_y    <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b1;
    end else begin
      vs_q        <= iVSYNC;
      oFRAME_TICK <= vs_rise;
      if (vs_rise) begin
        shadow_x <= iPOINT_X;
        shadow_y <= iPOINT_Y;
        if (frame_cnt == BLINK_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  // Cursor/border compares against the shadowed position; abs distance avoids wrap-around
  always_comb begin
    dh        = (iH_ADDR >= shadow_x) ? (iH_ADDR - shadow_x) : (shadow_x - iH_ADDR);
    dv        = (iV_ADDR >= shadow_y) ? (iV_ADDR - shadow_y) : (shadow_y - iV_ADDR);
    line_c    = (iH_ADDR == shadow_x) | (iV_ADDR == shadow_y);
    near_c    = (dh <= ONE) & (dv <= ONE);
    edge_c    = (iH_ADDR == '0) | (iH_ADDR == H_LAST) | (iV_ADDR == '0) | (iV_ADDR == V_LAST);
    bar_full  = iH_ADDR / BAR_DIV;
    bar_c     = (bar_full > ADDR_WIDTH'(7)) ? 3'd7 : bar_full[2:0];
    cur_vis_c = iCURSOR_EN & (~iBLINK_EN | blink_phase);
  end

  // Stage 1: register pixel, timing and compare results
  always_ff @(posedge VCLK or posedge RST) begin
    if (RST) begin
      s1_de      <= 1'b0;
      s1_hs      <= 1'b0;
      s1_vs      <= 1'b0;
      s1_planes  <= '0;
      s1_mode    <= 2'd0;
      s1_line    <= 1'b0;
      s1_near    <= 1'b0;
      s1_edge    <= 1'b0;
      s1_cur_en  <= 1'b0;
      s1_cur_vis <= 1'b0;
      s1_bar     <= 3'd0;
    end else begin
      s1_de      <= iDE;
      s1_hs      <= iHSYNC;
      s1_vs      <= iVSYNC;
      s1_planes  <= iPLANE_BITS;
      s1_mode    <= iMODE;
      s1_line    <= line_c;
      s1_near    <= near_c;
      s1_edge    <= edge_c;
      s1_cur_en  <= iCURSOR_EN;
      s1_cur_vis <= cur_vis_c;
      s1_bar     <= bar_c;
    end
  end

  // Colour select: blanking, then cursor lines, then per-mode rendering
  always_comb begin
    grey_msb = '0;
    for (int k = 0; k < NG; k++) begin
      grey_msb[NG-1-k] = s1_planes[1+k];
    end
    grey_pad = {grey_msb, {PIXEL_WIDTH{1'b0}}};
    grey     = grey_pad[NG+PIXEL_WIDTH-1 -: PIXEL_WIDTH];

    mask_g = s1_planes[0] ? MASK_LEVEL : '0;
    if (s1_cur_en & (s1_edge | s1_near)) begin
      mask_g = s1_planes[0] ? '0 : MASK_LEVEL;
    end

    rgb_c = '0;
    if (!s1_de) begin
      rgb_c = '0;
    end else if (s1_cur_vis & s1_line & (s1_mode != 2'd3)) begin
      rgb_c = CURSOR_RGB;
    end else begin
      case (s1_mode)
        2'd0:    rgb_c = {mask_g, mask_g, mask_g};
        2'd1:    rgb_c = {grey, grey, grey};
        2'd2:    rgb_c = s1_edge ? BORDER_RGB : {grey, grey, grey};
        default: rgb_c = {{PIXEL_WIDTH{s1_bar[2]}}, {PIXEL_WIDTH{s1_bar[1]}}, {PIXEL_WIDTH{s1_bar[0]}}};
      endcase
    end
  end

  // Stage 2: register colour and the matching sync/DE
  always_ff @(posedge VCLK or posedge RST) begin
    if (RST) begin
      oVGA_HSYNC <= 1'b0;
      oVGA_VSYNC <= 1'b0;
      oVGA_DE    <= 1'b0;
      oVGA_R     <= '0;
      oVGA_G     <= '0;
      oVGA_B     <= '0;
    end else begin
      oVGA_HSYNC <= s1_hs;
      oVGA_VSYNC <= s1_vs;
      oVGA_DE    <= s1_de;
      oVGA_R     <= rgb_c[3*PIXEL_WIDTH-1 -: PIXEL_WIDTH];
      oVGA_G     <= rgb_c[2*PIXEL_WIDTH-1 -: PIXEL_WIDTH];
      oVGA_B     <= rgb_c[PIXEL_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_vga_overlay_mixer.sv
// tb_vga_overlay_mixer: directed vectors for the overlay mixer, BLINK_FRAMES=2 for a short blink cycle.
// Latency: expects RGB/sync 2 VCLK after the inputs, frame tick 1 VCLK after iVSYNC rises.
// Backpressure: none; inputs driven on the falling edge, outputs sampled 1 ns after the rising edge.
module tb_vga_overlay_mixer;

  logic        VCLK = 1'b0;
  logic        RST  = 1'b1;
  logic        iVSYNC = 1'b0, iHSYNC = 1'b0, iDE = 1'b0;
  logic [10:0] iH_ADDR = '0, iV_ADDR = '0;
  logic [5:0]  iPLANE_BITS = '0;
  logic [1:0]  iMODE = 2'd0;
  logic        iCURSOR_EN = 1'b0, iBLINK_EN = 1'b0;
  logic [10:0] iPOINT_X = '0, iPOINT_Y = '0;
  logic        oVGA_HSYNC, oVGA_VSYNC, oVGA_DE, oFRAME_TICK;
  logic [7:0]  oVGA_R, oVGA_G, oVGA_B;

  int n_cmp = 0;
  int n_err = 0;

  vga_overlay_mixer #(.BLINK_FRAMES(2)) dut (
    .VCLK(VCLK), .RST(RST),
    .iVSYNC(iVSYNC), .iHSYNC(iHSYNC), .iDE(iDE),
    .iH_ADDR(iH_ADDR), .iV_ADDR(iV_ADDR), .iPLANE_BITS(iPLANE_BITS),
    .iMODE(iMODE), .iCURSOR_EN(iCURSOR_EN), .iBLINK_EN(iBLINK_EN),
    .iPOINT_X(iPOINT_X), .iPOINT_Y(iPOINT_Y),
    .oVGA_HSYNC(oVGA_HSYNC), .oVGA_VSYNC(oVGA_VSYNC), .oVGA_DE(oVGA_DE),
    .oVGA_R(oVGA_R), .oVGA_G(oVGA_G), .oVGA_B(oVGA_B),
    .oFRAME_TICK(oFRAME_TICK)
  );

  always #5 VCLK = ~VCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
    $fatal(1, "watchdog");
  end

  // drive one active pixel on the falling edge and return the RGB seen two rising edges later
  task automatic get_pix(input int h, input int v, input logic [5:0] pl, input logic [1:0] md,
                         output logic [23:0] rgb);
    @(negedge VCLK);
    iDE = 1'b1; iH_ADDR = h[10:0]; iV_ADDR = v[10:0]; iPLANE_BITS = pl; iMODE = md;
    @(posedge VCLK);
    @(posedge VCLK);
    #1;
    rgb = {oVGA_R, oVGA_G, oVGA_B};
  endtask

  // one VSYNC pulse with blanking; the tick must fire exactly once
  task automatic vsync_pulse();
    int ticks = 0;
    @(negedge VCLK);
    iDE = 1'b0; iVSYNC = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge VCLK);
      if (oFRAME_TICK) ticks++;
    end
    iVSYNC = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge VCLK);
      if (oFRAME_TICK) ticks++;
    end
    n_cmp++;
    if (ticks !== 1) begin
      n_err++;
      $display("FAIL frame_tick_count got %0d want 1", ticks);
    end
  endtask

  task automatic test_reset();
    iDE = 1'b1; iHSYNC = 1'b1; iVSYNC = 1'b0; iMODE = 2'd1; iPLANE_BITS = 6'b111110;
    repeat (3) @(posedge VCLK);
    #1;
    n_cmp++;
    if ({oVGA_R, oVGA_G, oVGA_B, oVGA_HSYNC, oVGA_VSYNC, oVGA_DE, oFRAME_TICK} !== 28'd0) begin
      n_err++;
      $display("FAIL reset_outputs got %h want 0",
               {oVGA_R, oVGA_G, oVGA_B, oVGA_HSYNC, oVGA_VSYNC, oVGA_DE, oFRAME_TICK});
    end
    @(negedge VCLK);
    iDE = 1'b0; iHSYNC = 1'b0;
    RST = 1'b0;
    repeat (3) @(negedge VCLK);
  endtask

  task automatic test_latency();
    logic [23:0] rgb;
    logic [5:0]  pl[3] = '{6'b000010, 6'b100000, 6'b000001};
    logic [23:0] ex[3] = '{24'h808080, 24'h080808, 24'h000000};
    @(negedge VCLK);
    iDE = 1'b1; iHSYNC = 1'b1; iMODE = 2'd1; iPLANE_BITS = 6'b111110;
    iH_ADDR = 11'd300; iV_ADDR = 11'd200;
    @(posedge VCLK); #1;
    n_cmp++;
    if ({oVGA_DE, oVGA_HSYNC, oVGA_R, oVGA_G, oVGA_B} !== 26'd0) begin
      n_err++;
      $display("FAIL latency_1cycle got %h want 0", {oVGA_DE, oVGA_HSYNC, oVGA_R, oVGA_G, oVGA_B});
    end
    @(posedge VCLK); #1;
    n_cmp++;
    if ({oVGA_DE, oVGA_HSYNC, oVGA_R, oVGA_G, oVGA_B} !== {2'b11, 24'hF8F8F8}) begin
      n_err++;
      $display("FAIL latency_2cycle got %h want %h", {oVGA_DE, oVGA_HSYNC, oVGA_R, oVGA_G, oVGA_B},
               {2'b11, 24'hF8F8F8});
    end
    iHSYNC = 1'b0;
    for (int i = 0; i < 3; i++) begin
      get_pix(300, 200, pl[i], 2'd1, rgb);
      n_cmp++;
      if (rgb !== ex[i]) begin
        n_err++;
        $display("FAIL grey_order[%0d] got %h want %h", i, rgb, ex[i]);
      end
    end
  endtask

  task automatic test_mode0_near();
    logic [23:0] rgb;
    int          hx[5] = '{101, 120, 100, 99, 100};
    int          vy[5] = '{99, 99, 5, 101, 5};
    logic [5:0]  pl[5] = '{6'd1, 6'd1, 6'd1, 6'd0, 6'd1};
    logic        ce[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [23:0] ex[5] = '{24'h000000, 24'hC0C0C0, 24'hFF0000, 24'hC0C0C0, 24'hC0C0C0};
    iPOINT_X = 11'd100; iPOINT_Y = 11'd100;
    vsync_pulse();
    for (int i = 0; i < 5; i++) begin
      iCURSOR_EN = ce[i];
      get_pix(hx[i], vy[i], pl[i], 2'd0, rgb);
      n_cmp++;
      if (rgb !== ex[i]) begin
        n_err++;
        $display("FAIL mode0_near[%0d] got %h want %h", i, rgb, ex[i]);
      end
    end
    iCURSOR_EN = 1'b1;
  endtask

  task automatic test_shadow();
    logic [23:0] rgb;
    int          hx[4] = '{200, 100, 200, 100};
    logic [23:0] ex[4] = '{24'h000000, 24'hFF0000, 24'hFF0000, 24'h000000};
    iPOINT_X = 11'd200;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) vsync_pulse();
      get_pix(hx[i], 5, 6'd0, 2'd0, rgb);
      n_cmp++;
      if (rgb !== ex[i]) begin
        n_err++;
        $display("FAIL shadow[%0d] got %h want %h", i, rgb, ex[i]);
      end
    end
  endtask

  task automatic test_no_wrap();
    logic [23:0] rgb;
    int          hx[5] = '{639, 2047, 0, 1, 1};
    int          vy[5] = '{479, 1, 0, 1, 1};
    logic [5:0]  pl[5] = '{6'd1, 6'd1, 6'd1, 6'd0, 6'd1};
    logic [23:0] ex[5] = '{24'h000000, 24'hC0C0C0, 24'hFF0000, 24'hC0C0C0, 24'h000000};
    iPOINT_X = 11'd0; iPOINT_Y = 11'd0;
    vsync_pulse();
    for (int i = 0; i < 5; i++) begin
      get_pix(hx[i], vy[i], pl[i], 2'd0, rgb);
      n_cmp++;
      if (rgb !== ex[i]) begin
        n_err++;
        $display("FAIL no_wrap[%0d] got %h want %h", i, rgb, ex[i]);
      end
    end
  endtask

  task automatic test_modes23();
    logic [23:0] rgb;
    int          hx[9] = '{0, 80, 639, 1000, 200, 0, 50, 0, 5};
    int          vy[9] = '{50, 50, 50, 50, 50, 50, 50, 0, 0};
    logic [1:0]  md[9] = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd2, 2'd2, 2'd3, 2'd2};
    logic        ce[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [23:0] ex[9] = '{24'h000000, 24'h0000FF, 24'hFFFFFF, 24'hFFFFFF, 24'h00FF00,
                           24'h00FF00, 24'h808080, 24'h000000, 24'hFF0000};
    for (int i = 0; i < 9; i++) begin
      iCURSOR_EN = ce[i];
      get_pix(hx[i], vy[i], 6'b000010, md[i], rgb);
      n_cmp++;
      if (rgb !== ex[i]) begin
        n_err++;
        $display("FAIL modes23[%0d] got %h want %h", i, rgb, ex[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  md[5] = '{2'd1, 2'd3, 2'd0, 2'd2, 2'd1};
    logic [5:0]  pl[5] = '{6'b000010, 6'b000010, 6'b000001, 6'b111110, 6'b111110};
    logic        de[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [23:0] ex[5] = '{24'h808080, 24'h00FFFF, 24'hC0C0C0, 24'hF8F8F8, 24'h000000};
    iCURSOR_EN = 1'b0;
    iH_ADDR = 11'd300; iV_ADDR = 11'd200;
    for (int i = 0; i < 7; i++) begin
      @(negedge VCLK);
      if (i >= 2) begin
        n_cmp++;
        if ({oVGA_R, oVGA_G, oVGA_B} !== ex[i-2]) begin
          n_err++;
          $display("FAIL back_to_back[%0d] got %h want %h", i - 2, {oVGA_R, oVGA_G, oVGA_B}, ex[i-2]);
        end
      end
      if (i < 5) begin
        iMODE = md[i]; iPLANE_BITS = pl[i]; iDE = de[i];
      end
    end
  endtask

  task automatic test_blink();
    logic [23:0] rgb;
    logic [23:0] want;
    @(negedge VCLK);
    RST = 1'b1;
    @(negedge VCLK);
    RST = 1'b0;
    iPOINT_X = 11'd0; iPOINT_Y = 11'd0;
    iCURSOR_EN = 1'b1; iBLINK_EN = 1'b1;
    for (int f = 0; f < 6; f++) begin
      want = ((f % 4) < 2) ? 24'hFF0000 : 24'hC0C0C0;
      get_pix(0, 5, 6'd0, 2'd0, rgb);
      n_cmp++;
      if (rgb !== want) begin
        n_err++;
        $display("FAIL blink_frame[%0d] got %h want %h", f, rgb, want);
      end
      vsync_pulse();
    end
    iBLINK_EN = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [23:0] rgb;
    iPOINT_X = 11'd300; iPOINT_Y = 11'd300;
    vsync_pulse();
    iHSYNC = 1'b1;
    get_pix(300, 5, 6'd0, 2'd0, rgb);
    n_cmp++;
    if ({rgb, oVGA_DE, oVGA_HSYNC} !== {24'hFF0000, 2'b11}) begin
      n_err++;
      $display("FAIL pre_reset_pixel got %h want %h", {rgb, oVGA_DE, oVGA_HSYNC}, {24'hFF0000, 2'b11});
    end
    @(posedge VCLK);
    #2 RST = 1'b1;
    #1;
    n_cmp++;
    if ({oVGA_R, oVGA_G, oVGA_B, oVGA_HSYNC, oVGA_VSYNC, oVGA_DE, oFRAME_TICK} !== 28'd0) begin
      n_err++;
      $display("FAIL async_reset_outputs got %h want 0",
               {oVGA_R, oVGA_G, oVGA_B, oVGA_HSYNC, oVGA_VSYNC, oVGA_DE, oFRAME_TICK});
    end
    @(negedge VCLK);
    RST = 1'b0;
    iHSYNC = 1'b0;
    get_pix(0, 5, 6'd0, 2'd0, rgb);
    n_cmp++;
    if (rgb !== 24'hFF0000) begin
      n_err++;
      $display("FAIL post_reset_cursor_origin got %h want ff0000", rgb);
    end
    get_pix(300, 5, 6'd0, 2'd0, rgb);
    n_cmp++;
    if (rgb !== 24'h000000) begin
      n_err++;
      $display("FAIL post_reset_old_cursor got %h want 000000", rgb);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_mode0_near();
    test_shadow();
    test_no_wrap();
    test_modes23();
    test_back_to_back();
    test_blink();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_overlay_mixer.md
Name: vga_overlay_mixer

Overview:
Parametrised successor to the single-mode VGA output stage. Takes per-pixel bit-plane samples from the line memories plus raster timing. Produces registered RGB with selectable render mode, a crosshair cursor, a frame border and a blinking cursor. Cursor coordinates are shadowed per frame to prevent tearing. Sits between the line-memory readout and the VGA/DVI transmitter.

Parameters:
ADDR_WIDTH, 11, width of raster and cursor coordinates
HACTIVE, 640, active pixels per line
VACTIVE, 480, active lines per frame
PIXEL_WIDTH, 8, bits per colour channel
NUM_PLANES, 6, bit-planes per pixel; plane 0 is the binary mask, planes 1..NUM_PLANES-1 are grey bits, MSB first (min 2)
MASK_LEVEL, 8'hC0, grey level of a set mask pixel in mode 0
CURSOR_RGB, 24'hFF0000, cursor colour {R,G,B}
BORDER_RGB, 24'h00FF00, frame-border colour in mode 2
BLINK_FRAMES, 30, frames per blink half-period (>=1)

Ports:
VCLK  in  1  pixel clock
RST  in  1  asynchronous active-high reset
iVSYNC  in  1  vertical sync, active-high
iHSYNC  in  1  horizontal sync
iDE  in  1  active-video enable
iH_ADDR  in  ADDR_WIDTH  current column
iV_ADDR  in  ADDR_WIDTH  current line
iPLANE_BITS  in  NUM_PLANES  plane bits of the current pixel, aligned with iH_ADDR
iMODE  in  2  render mode, sampled per pixel
iCURSOR_EN  in  1  cursor/overlay enable
iBLINK_EN  in  1  cursor blink enable
iPOINT_X  in  ADDR_WIDTH  cursor column, live
iPOINT_Y  in  ADDR_WIDTH  cursor line, live
oVGA_HSYNC  out  1  iHSYNC delayed 2 cycles
oVGA_VSYNC  out  1  iVSYNC delayed 2 cycles
oVGA_DE  out  1  iDE delayed 2 cycles
oVGA_R/oVGA_G/oVGA_B  out  PIXEL_WIDTH each  pixel colour
oFRAME_TICK  out  1  one-cycle pulse on the registered iVSYNC rising edge

Behaviour:
- Reset: every output 0. Shadow X/Y = 0. Frame counter = 0. Blink phase = 1 (visible).
- Pipeline: 2 cycles. Stage 1 registers plane bits, mode, DE and the compare flags. Stage 2 registers RGB. Sync/DE use the same 2-stage delay, so pixel and timing stay aligned.
- Frame edge: iVSYNC is registered once. On rising edge detection:
  - pulse oFRAME_TICK;
  - latch iPOINT_X/Y into the shadow registers;
  - increment the frame counter.
- Cursor compares use only the shadow registers. A mid-frame change of iPOINT takes effect the next frame.
- Blink: when the frame counter reaches BLINK_FRAMES-1 on a tick, it clears and the phase toggles. The cursor is visible when iCURSOR_EN=1 and (iBLINK_EN=0 or phase=1). Clearing iBLINK_EN does not reset the phase.
- Compare flags:
  - line = (H==SX) | (V==SY)
  - near = |H-SX|<=1 & |V-SY|<=1; no wrap, so SX=0 does not match H=2^ADDR_WIDTH-1
  - edge = H==0 | H==HACTIVE-1 | V==0 | V==VACTIVE-1
- Colour priority, first match wins:
  1. DE=0 -> 0.
  2. Cursor visible & line & mode!=3 -> CURSOR_RGB.
  3. Otherwise by mode:
     - Mode 0 (binary): g = plane0 ? MASK_LEVEL : 0. If iCURSOR_EN & (edge|near), g is inverted (MASK_LEVEL<->0). R=G=B=g.
     - Mode 1 (grey): grey bits MSB-aligned into PIXEL_WIDTH, LSBs zero-filled; excess planes drop LSBs. R=G=B.
     - Mode 2 (grey+border): as mode 1, but edge -> BORDER_RGB regardless of iCURSOR_EN.
     - Mode 3 (test bars): 8 vertical bars of width HACTIVE/8. Bar index b = H/(HACTIVE/8), clamped to 7. R={PIXEL_WIDTH{b[2]}}, G={..b[1]}, B={..b[0]}. No cursor.
- iMODE change mid-line: applies from the next pixel sampled, no glitch beyond that pixel.
- Async RST mid-frame: outputs 0 immediately. After release, the first frame shows the cursor at (0,0) until the next VSYNC edge.

Test Plan:
- Reset then release with DE=1, mode1, planes=6'b111110 -> RGB=8'hF8 exactly 2 cycles after the input; sync/DE delayed 2.
- Mode0, iCURSOR_EN=1, SX=SY=100 latched: pixel (101,99) with plane0=1 -> 8'h00; (120,99) plane0=1 -> 8'hC0; (100,5) -> FF/00/00.
- iPOINT_X 100->200 mid-frame -> cursor stays at column 100 until the next iVSYNC rise, then column 200; oFRAME_TICK single pulse.
- iBLINK_EN=1, BLINK_FRAMES=2 -> cursor visible frames 0-1, hidden 2-3, visible 4-5.
- SX=SY=0, mode0 -> (639,479) and H=2047 are not treated as near; (0,0) is red; (1,1) inverted.
- Mode3, HACTIVE=640 -> H=0 RGB=000000, H=80 0000FF, H=639 FFFFFF; mode2 edge pixel -> 00FF00.
